// File: rtl/joint_ramp_pkg.sv
// Shared definitions for the joint command conditioning path.
//   CMD_W          : width of signed joint commands
//   ramp_state_e   : ramp FSM state, fixed encoding (readback register)
//   *_DEF          : default prescaler, slew and watchdog settings
//   ramp_step()    : one slew-limited step from cur toward tgt
package joint_ramp_pkg;

    localparam int CMD_W = 32;

    localparam int              STEP_DIV_DEF   = 1000;
    localparam logic [31:0]     ACCEL_DEF      = 32'd64;
    localparam logic [31:0]     WDT_CYCLES_DEF = 32'd4_800_000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2,
        ST_STOP = 2'd3
    } ramp_state_e;

    // The difference is taken one bit wider than the command so that
    // full-scale swings (+max to -max) cannot wrap. When the remaining
    // distance exceeds accel, cur +/- accel lies strictly between cur and
    // tgt, so the 32-bit result is always representable.
    function automatic logic signed [CMD_W-1:0] ramp_step(
        input logic signed [CMD_W-1:0] cur,
        input logic signed [CMD_W-1:0] tgt,
        input logic        [CMD_W-1:0] accel
    );
        logic signed [CMD_W:0] diff;
        logic signed [CMD_W:0] lim;
        diff = {tgt[CMD_W-1], tgt} - {cur[CMD_W-1], cur};
        lim  = {1'b0, accel};
        if (diff > lim)
            ramp_step = cur + accel;
        else if (diff < -lim)
            ramp_step = cur - accel;
        else
            ramp_step = tgt;
    endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Update-tick prescaler for joint plugins.
//   clk, rst_n : system clock, asynchronous active-low reset
//   tick       : registered one-cycle pulse, high while the internal
//                count sits at STEP_DIV-1 (once every STEP_DIV clocks)
module ramp_tick_gen
    import joint_ramp_pkg::*;
#(
    parameter int STEP_DIV = STEP_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

    logic [CW-1:0] cnt;

    // tick is registered from the count one step early so that it is
    // high exactly during the cycle in which cnt == STEP_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            if (cnt == CW'(STEP_DIV - 1))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            tick <= (cnt == CW'(STEP_DIV - 2));
        end
    end

endmodule

// File: rtl/joint_cmd_ramp.sv
// Slew-rate limiter and comms watchdog in front of joint_rcservo.
//   clk, rst_n    : system clock, asynchronous active-low reset
//   cmdIn         : signed host command, captured on cmdValid
//   cmdValid      : one-cycle strobe qualifying cmdIn (feeds the watchdog)
//   enable        : low requests a controlled ramp to zero
//   jointFreqCmd  : slew-limited command, moves at most ACCEL per tick
//   atTarget      : jointFreqCmd equals the effective target
//   wdtTripped    : sticky, set after WDT_CYCLES clocks without cmdValid
//   state         : registered FSM state (IDLE/RAMP/HOLD/STOP)
module joint_cmd_ramp
    import joint_ramp_pkg::*;
#(
    parameter int          STEP_DIV   = STEP_DIV_DEF,
    parameter logic [31:0] ACCEL      = ACCEL_DEF,
    parameter logic [31:0] WDT_CYCLES = WDT_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [CMD_W-1:0] cmdIn,
    input  logic                    cmdValid,
    input  logic                    enable,
    output logic signed [CMD_W-1:0] jointFreqCmd,
    output logic                    atTarget,
    output logic                    wdtTripped,
    output logic [1:0]              state
);

    logic                    tick;
    logic signed [CMD_W-1:0] target;
    logic signed [CMD_W-1:0] eff_target;
    logic [31:0]             wdt_cnt;
    logic                    stop_req;
    ramp_state_e             state_q, state_nxt;

    ramp_tick_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Host target, accepted whether or not the joint is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            target <= '0;
        else if (cmdValid)
            target <= cmdIn;
    end

    // Watchdog: the trip is set on the same edge the count reaches
    // WDT_CYCLES, so the flag rises WDT_CYCLES clocks after the last
    // strobe. A strobe on that edge takes priority and cancels the trip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt    <= '0;
            wdtTripped <= 1'b0;
        end else if (cmdValid) begin
            wdt_cnt    <= '0;
            wdtTripped <= 1'b0;
        end else begin
            if (wdt_cnt != WDT_CYCLES)
                wdt_cnt <= wdt_cnt + 32'd1;
            if (wdt_cnt == WDT_CYCLES - 32'd1)
                wdtTripped <= 1'b1;
        end
    end

    assign stop_req   = !enable || wdtTripped;
    assign eff_target = stop_req ? '0 : target;
    assign atTarget   = (jointFreqCmd == eff_target);

    // Output only moves on tick edges; a strobe coincident with the tick
    // still sees the old target because target updates on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            jointFreqCmd <= '0;
        else if (tick)
            jointFreqCmd <= ramp_step(jointFreqCmd, eff_target, ACCEL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_HOLD;
        if (stop_req && (jointFreqCmd != '0))
            state_nxt = ST_STOP;
        else if ((jointFreqCmd == '0) && (eff_target == '0))
            state_nxt = ST_IDLE;
        else if (jointFreqCmd != eff_target)
            state_nxt = ST_RAMP;
    end

    assign state = state_q;

endmodule

// File: doc/joint_cmd_ramp.md
Name: joint_cmd_ramp

Overview:
- Upstream conditioning stage for joint_rcservo.
- Receives raw signed joint commands from the host interface (SPI register bank) and drives joint_rcservo's jointFreqCmd.
- Limits the command slew rate to a fixed step per update tick.
- A communications watchdog ramps the command to zero when host updates stop.

Parameters:
- STEP_DIV, 1000: clocks per ramp update tick (>=2).
- ACCEL, 32'd64: maximum absolute change of jointFreqCmd per tick (>0).
- WDT_CYCLES, 32'd4_800_000: clocks without cmdValid before the watchdog trips (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmdIn  in  32 signed  requested joint command from host
- cmdValid  in  1  one-cycle strobe; cmdIn is valid
- enable  in  1  joint enable from host; low = controlled stop
- jointFreqCmd  out  32 signed  slew-limited command to joint_rcservo
- atTarget  out  1  jointFreqCmd equals the effective target
- wdtTripped  out  1  sticky watchdog-trip flag
- state  out  2  current FSM state (debug/readback)

Behaviour:
- Reset is asynchronous, active-low, and applies to every register.
  - Reset values: jointFreqCmd=0, target=0, atTarget=1, wdtTripped=0, state=IDLE, prescaler=0, wdt counter=0.
- Prescaler:
  - Counts 0..STEP_DIV-1 and wraps.
  - tick is a registered one-cycle pulse, asserted when the count equals STEP_DIV-1, i.e. once every STEP_DIV clocks.
- Target register:
  - On cmdValid, target <= cmdIn.
  - cmdValid is accepted regardless of enable.
- Effective target:
  - Equals 0 if enable==0 or wdtTripped==1.
  - Otherwise equals target.
- Watchdog:
  - Counter clears on cmdValid; otherwise it increments and saturates at WDT_CYCLES.
  - When the count reaches WDT_CYCLES, wdtTripped <= 1.
  - wdtTripped clears only on the next cmdValid.
  - If cmdValid arrives in the same cycle the count reaches WDT_CYCLES, cmdValid wins: no trip, counter cleared.
- Ramp (on tick cycles only):
  - diff = eff_target - jointFreqCmd, computed in 33-bit signed arithmetic (no overflow).
  - If |diff| <= ACCEL: jointFreqCmd <= eff_target.
  - Else: jointFreqCmd <= jointFreqCmd ± ACCEL (toward eff_target).
  - jointFreqCmd changes only in the cycle after tick is asserted; it is held at all other times.
  - A tick in the same cycle as cmdValid uses the old target; the new target takes effect on the next tick.
- Reversal: a sign change ramps through zero; there is no jump.
- atTarget is combinational: (jointFreqCmd == eff_target).
- FSM (registered; evaluated every cycle):
  - STOP: (enable==0 or wdtTripped) and jointFreqCmd != 0.
  - IDLE: jointFreqCmd == 0 and eff_target == 0.
  - RAMP: otherwise, when jointFreqCmd != eff_target.
  - HOLD: jointFreqCmd == eff_target != 0.
  - Priority: STOP > IDLE > RAMP > HOLD.
  - Encoding: IDLE=0, RAMP=1, HOLD=2, STOP=3.
- Reset mid-ramp: output goes to 0 immediately (asynchronous). This is the only path that allows a non-ramped change.
- Extreme values (±2^31-1 targets) must not wrap; the clamp rule above guarantees this.

Decomposition:
- Shared package joint_ramp_pkg holds:
  - CMD_W=32
  - the FSM state enum (IDLE, RAMP, HOLD, STOP) with fixed encodings
  - the default values of STEP_DIV, ACCEL and WDT_CYCLES
- Sub-module ramp_tick_gen: STEP_DIV prescaler producing the registered tick pulse. Reused by later joint plugins.
- Watchdog, target register, ramp datapath and FSM stay in joint_cmd_ramp.

Test Plan (STEP_DIV=4, ACCEL=10, WDT_CYCLES=200 unless noted):
- Release reset, enable=1, cmdValid with cmdIn=35:
  - Output sequence 10, 20, 30, 35, with one change per 4 clocks.
  - atTarget rises when the output reaches 35; state goes RAMP then HOLD.
- At 35, cmdValid with cmdIn=-15:
  - Output steps 25, 15, 5, -5, -15 with no jump.
  - state goes RAMP then HOLD.
- Hold 100, then stop strobing:
  - wdtTripped asserts exactly 200 clocks after the last cmdValid.
  - Output ramps to 0 at 10 per tick with state=STOP, then state=IDLE.
  - The next cmdValid clears wdtTripped.
- cmdValid in the exact cycle the watchdog count hits 200 -> no trip.
- cmdValid coincident with tick -> that tick steps toward the old target.
- enable=0 while at 50 -> ramps to 0 with state=STOP, while target still reads 50.
  - enable=1 -> ramps back to 50.
- ACCEL=32'h4000_0000, alternate cmdIn between 32'h7FFF_FFFF and 32'h8000_0000:
  - No overflow/wrap; every step is <= ACCEL.
  - Assert rst_n low mid-ramp: output is 0 within the same cycle, asynchronously.
